alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: RR_INIT, default 0, requester holding priority after reset.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_req_valid0 / i_req_valid1  input  1  request k presents an operation.
REQ-006 iv_a0 / iv_a1  input  32  operand A of requester k.
REQ-007 iv_b0 / iv_b1  input  32  operand B of requester k.
REQ-008 iv_op0 / iv_op1  input  5  ALUop of requester k (shared-package encoding).
REQ-009 o_req_ready0 / o_req_ready1  output  1  request k accepted this cycle when valid and ready are both high.
REQ-010 o_rsp_valid  output  1  response register holds a result.
REQ-011 ov_rsp_result  output  32  registered ALU result.
REQ-012 o_rsp_zero  output  1  registered zero flag (result == 0).
REQ-013 o_rsp_id  output  1  requester index that owns the response.
REQ-014 i_rsp_ready  input  1  consumer accepts the response this cycle.

Function
REQ-015 The block SHALL share one combinational ALU between two requesters, using a single-entry response register.
REQ-016 FSM states: EMPTY (o_rsp_valid=0) and FULL (o_rsp_valid=1).
REQ-017 slot_free = EMPTY or (FULL and i_rsp_ready).
REQ-018 Grant, combinational: only one valid -> that requester; both valid -> the requester not holding priority loses, i.e. grant = prio.
REQ-019 o_req_ready_k = slot_free and grant_k; at most one ready is high per cycle; a ready SHALL NOT rise for a requester whose valid is low.
REQ-020 On acceptance, the ALU result, zero flag and requester index SHALL be captured at that edge: latency is exactly 1 cycle (accept at edge N -> o_rsp_valid high after edge N).
REQ-021 After an accepted grant to k, priority SHALL move to the other requester; with no acceptance, priority is unchanged.
REQ-022 Transitions: EMPTY + accept -> FULL; FULL + i_rsp_ready + accept -> FULL with new data (back-to-back, no bubble); FULL + i_rsp_ready, no accept -> EMPTY; FULL + no i_rsp_ready -> FULL.
REQ-023 While FULL and i_rsp_ready low, ov_rsp_result, o_rsp_zero and o_rsp_id SHALL hold stable and both readies SHALL be low.
REQ-024 An undefined ALUop SHALL be forwarded unchanged; the result is 0 and o_rsp_zero is 1.
REQ-025 Requester inputs may change while unaccepted; only values present on the accepting edge are captured.
REQ-026 Sustained throughput SHALL be one operation per cycle when i_rsp_ready is held high.

Reset
REQ-027 Reset assertion SHALL immediately force o_rsp_valid=0, ov_rsp_result=0, o_rsp_zero=0, o_rsp_id=0, prio=RR_INIT and state EMPTY, independent of i_clk.
REQ-028 A response pending at reset SHALL be discarded, not replayed.
REQ-029 On the first edge after deassertion, the block SHALL accept a request when one is valid.

Structure
REQ-030 The shared package SHALL hold the ALUop encodings (ADD 00000, SUB 00010, SLL 00100, SLT 01000, SLTU 01100, XOR 10000, SRL 10100, SRA 10110, OR 11000, AND 11100, BGE 11010, BGEU 11110, LUI 11101), the state enumeration and the requester-id type.
REQ-031 The block SHALL instantiate the existing ALU once as its only sub-module; operand and op muxes, grant, FSM and response register are local.

Verification
REQ-032 Single request: valid0, A=5, B=3, op=SUB, i_rsp_ready=1 -> ready0 high that cycle; next cycle o_rsp_valid=1, result=2, zero=0, id=0.
REQ-033 Contention: both valid every cycle, RR_INIT=0, ready held high -> grants alternate 0,1,0,1; one response per cycle, no bubbles.
REQ-034 Backpressure: FULL with result 0x0000_00FF, i_rsp_ready low for 4 cycles while valid1 high -> outputs stable, ready1 low; when i_rsp_ready rises, ready1 high the same cycle and the new result follows.
REQ-035 Zero/default: A=7, B=7, SUB -> result 0, zero=1; op=00001 -> result 0, zero=1.
REQ-036 Reset mid-operation: FULL, assert i_rst_n low between edges -> o_rsp_valid 0 immediately; after release, priority restarts at RR_INIT.
REQ-037 Ops: SRA on A=0x8000_0000, B=4 -> 0xF800_0000; SLTU on A=1, B=0xFFFF_FFFF -> 1; LUI on B=0x1234_5000 -> 0x1234_5000.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg -- shared definitions for the two-requester ALU arbiter.
// Holds the 5-bit ALUop encodings, the response-slot state enumeration,
// the requester-id type and the registered response record.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'b00100;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'b01000;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'b01100;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'b10000;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'b10100;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'b10110;
  localparam logic [OP_W-1:0] ALU_OR   = 5'b11000;
  localparam logic [OP_W-1:0] ALU_AND  = 5'b11100;
  localparam logic [OP_W-1:0] ALU_BGE  = 5'b11010;
  localparam logic [OP_W-1:0] ALU_BGEU = 5'b11110;
  localparam logic [OP_W-1:0] ALU_LUI  = 5'b11101;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    req_id_t           id;
  } rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- request/response bundle between two requesters, the
// arbiter and the response consumer.
//   master : testbench / surrounding logic (drives requests, i_rsp_ready)
//   slave  : alu_arbiter (drives readies and the response register)
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              i_req_valid0, i_req_valid1;
  logic [DATA_W-1:0] iv_a0, iv_a1;
  logic [DATA_W-1:0] iv_b0, iv_b1;
  logic [OP_W-1:0]   iv_op0, iv_op1;
  logic              o_req_ready0, o_req_ready1;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] ov_rsp_result;
  logic              o_rsp_zero;
  req_id_t           o_rsp_id;
  logic              i_rsp_ready;

  modport master (
    output i_req_valid0, i_req_valid1, iv_a0, iv_a1, iv_b0, iv_b1,
           iv_op0, iv_op1, i_rsp_ready,
    input  o_req_ready0, o_req_ready1, o_rsp_valid, ov_rsp_result,
           o_rsp_zero, o_rsp_id
  );

  modport slave (
    input  i_req_valid0, i_req_valid1, iv_a0, iv_a1, iv_b0, iv_b1,
           iv_op0, iv_op1, i_rsp_ready,
    output o_req_ready0, o_req_ready1, o_rsp_valid, ov_rsp_result,
           o_rsp_zero, o_rsp_id
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu -- purely combinational 32-bit ALU.
//   a, b   : operands
//   op     : ALUop (package encoding); unknown codes yield 0
//   result : ALU output
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_BGE:  result = {31'b0, $signed(a) >= $signed(b)};
      ALU_BGEU: result = {31'b0, a >= b};
      ALU_LUI:  result = b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter -- two requesters share one combinational ALU; results land
// in a single-entry response register (1-cycle latency, 1 op/cycle when
// the consumer keeps i_rsp_ready high).
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : request/response bundle (alu_arbiter_if.slave)
//   RR_INIT        : requester holding priority after reset
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_arbiter_if.slave  bus
);
  state_e            state_q, state_d;
  req_id_t           prio_q, prio_d;
  rsp_t              rsp_q;
  req_id_t           grant;
  logic              slot_free, accept;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [OP_W-1:0]   alu_op;

  // Contention goes to the priority holder; a lone valid wins outright.
  always_comb begin
    if (bus.i_req_valid0 && bus.i_req_valid1) grant = prio_q;
    else                                      grant = bus.i_req_valid1;
  end

  // A full slot frees up in the same cycle the consumer drains it.
  assign slot_free = (state_q == ST_EMPTY) || bus.i_rsp_ready;
  assign accept    = slot_free && (bus.i_req_valid0 || bus.i_req_valid1);

  assign bus.o_req_ready0 = accept && !grant;
  assign bus.o_req_ready1 = accept &&  grant;

  assign alu_a  = grant ? bus.iv_a1  : bus.iv_a0;
  assign alu_b  = grant ? bus.iv_b1  : bus.iv_b0;
  assign alu_op = grant ? bus.iv_op1 : bus.iv_op0;

  alu_arbiter_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      prio_q  <= RR_INIT;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (bus.i_rsp_ready) state_d = accept ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) prio_d = !grant;
  end

  // Data is only written on accept; after a drain it is stale but masked
  // by o_rsp_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_q <= '0;
    end else if (accept) begin
      rsp_q.result <= alu_res;
      rsp_q.zero   <= (alu_res == '0);
      rsp_q.id     <= grant;
    end
  end

  assign bus.o_rsp_valid   = (state_q == ST_FULL);
  assign bus.ov_rsp_result = rsp_q.result;
  assign bus.o_rsp_zero    = rsp_q.zero;
  assign bus.o_rsp_id      = rsp_q.id;
endmodule
